// File: rtl/palindrome_builder.sv
// Bit-serial binary palindrome generator: leading-one scan, then mirror loop.
// Odd-length builds are available only when PAL_BUILD_ODD_EN is defined.
module palindrome_builder #(
    parameter int unsigned SEED_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go_i,
    input  logic                  odd_i,
    input  logic [SEED_W-1:0]     seed,
    output logic [2*SEED_W-1:0]   number,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [3:0]            state_o
);

    localparam int unsigned NUM_W = 2 * SEED_W;
    localparam int unsigned CNT_W = $clog2(SEED_W + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SCAN   = 4'd2,
        S_MIRROR = 4'd3,
        S_DONE   = 4'd4
    } state_t;

    state_t             state, state_n;
    logic [SEED_W-1:0]  t, t_n;
    logic [SEED_W-1:0]  r, r_n;
    logic [NUM_W-1:0]   acc, acc_n;
    logic [NUM_W-1:0]   number_n;
    logic [CNT_W-1:0]   len, len_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               odd_eff;

`ifdef PAL_BUILD_ODD_EN
    logic odd_q;

    // Mode is latched with the accepted request so later odd_i changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            odd_q <= 1'b0;
        end else if (state == S_IDLE && go_i) begin
            odd_q <= odd_i;
        end
    end

    assign odd_eff = odd_q;
`else
    logic unused_odd;

    assign unused_odd = odd_i;
    assign odd_eff    = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_n  = state;
        t_n      = t;
        r_n      = r;
        acc_n    = acc;
        len_n    = len;
        cnt_n    = cnt;
        number_n = number;

        case (state)
            S_IDLE: begin
                if (go_i) begin
                    if (seed == '0) begin
                        number_n = '0;
                        state_n  = S_DONE;
                    end else begin
                        t_n     = seed;
                        r_n     = seed;
                        acc_n   = NUM_W'(seed);
                        len_n   = CNT_W'(SEED_W);
                        state_n = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (t[SEED_W-1]) begin
                    // Odd mode drops b_0 from the mirror copy so the centre bit is not repeated.
                    if (odd_eff) begin
                        cnt_n = len - CNT_W'(1);
                        r_n   = r >> 1;
                    end else begin
                        cnt_n = len;
                    end
                    state_n = S_MIRROR;
                end else begin
                    t_n   = {t[SEED_W-2:0], 1'b0};
                    len_n = len - CNT_W'(1);
                end
            end
            S_MIRROR: begin
                if (cnt == '0) begin
                    number_n = acc;
                    state_n  = S_DONE;
                end else begin
                    acc_n = {acc[NUM_W-2:0], r[0]};
                    r_n   = r >> 1;
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            t       <= '0;
            r       <= '0;
            acc     <= '0;
            len     <= '0;
            cnt     <= '0;
            number  <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
            state_o <= 4'd0;
        end else begin
            state   <= state_n;
            t       <= t_n;
            r       <= r_n;
            acc     <= acc_n;
            len     <= len_n;
            cnt     <= cnt_n;
            number  <= number_n;
            done_o  <= (state_n == S_DONE);
            busy_o  <= (state_n == S_SCAN) || (state_n == S_MIRROR);
            state_o <= state_n;
        end
    end

endmodule

// File: doc/palindrome_builder.md
# palindrome_builder

Generator-side counterpart of the palindrome checker: builds a binary palindrome from a seed and presents it on a 32-bit `number` bus with a go/done handshake. Its output is directly consumable as the checker's `number` input. It is used in the NumberAnalyzer loopback so the checker can be exercised with known-palindromic operands. The build is bit-serial: a leading-one scan, then a mirror loop, one bit per cycle.

## Interface
- `SEED_W`, default 16: seed width. `number` width is 2*SEED_W. The cycle counts below assume 16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go_i`  in  1  start request; sampled only in IDLE.
- `odd_i`  in  1  1 selects an odd-length palindrome with the seed LSB as the centre bit; 0 selects even length. Sampled with `go_i`.
- `seed`  in  SEED_W  source bits; sampled with `go_i`.
- `number`  out  2*SEED_W  built palindrome, right-aligned and zero-extended.
- `done_o`  out  1  one-cycle pulse; `number` is valid from this cycle on.
- `busy_o`  out  1  high in SCAN and MIRROR.
- `state_o`  out  4  current state encoding, for debug and bench sync.

## Operation
- Let L be the index of the highest set bit of `seed` plus one, and b_i the seed bits.
- Even mode result: (seed << L) | rev_L(seed), which is 2L bits long.
- Odd mode result: (seed << (L-1)) | (rev_L(seed) & ((1<<(L-1))-1)), which is 2L-1 bits long with b_0 at the centre.
- State encoding: IDLE=0, SCAN=2, MIRROR=3, DONE=4. All other codes are unreachable and decode to IDLE.
- IDLE, on `go_i`=1:
  - seed==0: `number`<=0, go to DONE.
  - Otherwise: capture `seed` into the scan copy t, the mirror copy r and the accumulator acc; set len<=SEED_W; latch odd; go to SCAN.
- SCAN, per cycle:
  - t[MSB]=1: cnt<=len, or len-1 when odd. When odd, also r<=r>>1 so b_0 is not duplicated. Go to MIRROR.
  - t[MSB]=0: t<<=1, len<=len-1.
- MIRROR, per cycle:
  - cnt==0: `number`<=acc, go to DONE.
  - Otherwise: acc<={acc[2*SEED_W-2:0], r[0]}, r<=r>>1, cnt<=cnt-1.
- DONE: `done_o`=1, then go to IDLE unconditionally.
- `go_i` outside IDLE is ignored; there is no queuing. Seed and mode changes during a build have no effect.
- `number` holds its last value until the next DONE.

## Timing
- Reset values: state IDLE, `number`=0, `done_o`=0, `busy_o`=0, `state_o`=0. Internal registers are cleared.
- Reset asserted mid-build aborts the build immediately. No `done_o` is produced and `number` reads 0.
- `go_i` accepted at edge e0: SCAN spans 17-L cycles and MIRROR spans cnt+1 cycles.
- `done_o` is high in the cycle after the last MIRROR cycle.
- Zero seed: `done_o` is high in the cycle right after e0.
- Longest path (L=16, even): 1 + 17 + 1 = 19 cycles from acceptance to `done_o`.
- `go_i` held high continuously: a new build is accepted in the IDLE cycle that follows each DONE.
- `done_o`, `busy_o` and `state_o` are registered outputs, so there are no combinational paths from the inputs.

## Configuration
- `PAL_BUILD_ODD_EN` defined: odd mode is supported as described above.
- Undefined: `odd_i` is ignored and treated as 0. Only even palindromes are built and the odd-skip logic is not synthesized. The port list is unchanged.

## Test plan
- Even build: seed=0xB4, odd_i=0, go_i pulse -> 9 SCAN and 9 MIRROR cycles, then `done_o`=1 with `number`=0x0000B42D.
- Odd build (macro defined): seed=0xB4, odd_i=1 -> 9 SCAN and 8 MIRROR cycles, then `number`=0x00005A2D.
- Boundary seeds:
  - seed=0xFFFF even -> `number`=0xFFFFFFFF after 19 cycles.
  - seed=0x0001 odd -> `number`=0x00000001.
  - seed=0 -> `done_o` in the next cycle with `number`=0.
- go_i held high, and seed changed to 0x0003 mid-build -> the current result is unaffected. The next build starts in the IDLE cycle after DONE and yields 0x0000000F.
- Reset low during MIRROR -> `state_o`=0, `number`=0, `busy_o`=0, and no `done_o` pulse. A subsequent go_i with seed 0xB4 produces 0x0000B42D.
- Loopback: feed `number` into the palindrome checker for seeds 1..255 in both modes -> the checker reports result=1 every time.
